// File: rtl/umi_loc_arbiter.sv
// Two-requester round-robin arbiter for the umi_endpoint local memory port.
// Optional per-requester accept counters are built when UMI_LOC_ARB_STATS_EN is defined.
module umi_loc_arbiter #(
  parameter int AW   = 64,
  parameter int DW   = 256,
  parameter int HOLD = 4
) (
  input  logic          clk,
  input  logic          nreset,
  input  logic [AW-1:0] req0_addr,
  input  logic          req0_write,
  input  logic          req0_read,
  input  logic [7:0]    req0_opcode,
  input  logic [2:0]    req0_size,
  input  logic [7:0]    req0_len,
  input  logic [DW-1:0] req0_wrdata,
  output logic          req0_ready,
  output logic [DW-1:0] req0_rddata,
  input  logic [AW-1:0] req1_addr,
  input  logic          req1_write,
  input  logic          req1_read,
  input  logic [7:0]    req1_opcode,
  input  logic [2:0]    req1_size,
  input  logic [7:0]    req1_len,
  input  logic [DW-1:0] req1_wrdata,
  output logic          req1_ready,
  output logic [DW-1:0] req1_rddata,
  output logic [AW-1:0] loc_addr,
  output logic          loc_write,
  output logic          loc_read,
  output logic [7:0]    loc_opcode,
  output logic [2:0]    loc_size,
  output logic [7:0]    loc_len,
  output logic [DW-1:0] loc_wrdata,
  input  logic          loc_ready,
  input  logic [DW-1:0] loc_rddata
`ifdef UMI_LOC_ARB_STATS_EN
  ,
  output logic [31:0]   grant_count0,
  output logic [31:0]   grant_count1
`endif
);

  localparam int CW = $clog2(HOLD + 1);

  typedef enum logic [1:0] {IDLE, OWN0, OWN1} state_t;

  state_t        state, state_nxt;
  logic          last, last_nxt;
  logic [CW-1:0] cnt, cnt_nxt;

  logic pend0, pend1, own_pend, oth_pend, accept;

  assign pend0    = req0_write | req0_read;
  assign pend1    = req1_write | req1_read;
  assign own_pend = (state == OWN0) ? pend0 : pend1;
  assign oth_pend = (state == OWN0) ? pend1 : pend0;
  assign accept   = (state != IDLE) & own_pend & loc_ready;

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!nreset) begin
      state <= IDLE;
      last  <= 1'b1;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      last  <= last_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // NOTE: every signal written here gets a default first, so no path can infer a latch.
  always_comb begin
    state_nxt = state;
    last_nxt  = last;
    cnt_nxt   = cnt;
    case (state)
      IDLE: begin
        cnt_nxt = '0;
        if (pend0 && pend1) state_nxt = last ? OWN0 : OWN1;
        else if (pend0)     state_nxt = OWN0;
        else if (pend1)     state_nxt = OWN1;
      end
      OWN0, OWN1: begin
        if (!own_pend) begin
          state_nxt = oth_pend ? ((state == OWN0) ? OWN1 : OWN0) : IDLE;
        end else if (accept && (int'(cnt) + 1 == HOLD) && oth_pend) begin
          state_nxt = (state == OWN0) ? OWN1 : OWN0;
        end else if (accept && (int'(cnt) != HOLD)) begin
          cnt_nxt = cnt + CW'(1);
        end
        // Leaving a tenure hands the round-robin pointer to the departing owner.
        if (state_nxt != state) begin
          last_nxt = (state == OWN1);
          cnt_nxt  = '0;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Return paths depend only on state and loc_*, never on the other requester.
  always_comb begin
    loc_addr    = '0;
    loc_write   = 1'b0;
    loc_read    = 1'b0;
    loc_opcode  = '0;
    loc_size    = '0;
    loc_len     = '0;
    loc_wrdata  = '0;
    req0_ready  = 1'b0;
    req1_ready  = 1'b0;
    req0_rddata = '0;
    req1_rddata = '0;
    case (state)
      OWN0: begin
        loc_addr    = req0_addr;
        loc_write   = req0_write;
        loc_read    = req0_read;
        loc_opcode  = req0_opcode;
        loc_size    = req0_size;
        loc_len     = req0_len;
        loc_wrdata  = req0_wrdata;
        req0_ready  = loc_ready;
        req0_rddata = loc_rddata;
      end
      OWN1: begin
        loc_addr    = req1_addr;
        loc_write   = req1_write;
        loc_read    = req1_read;
        loc_opcode  = req1_opcode;
        loc_size    = req1_size;
        loc_len     = req1_len;
        loc_wrdata  = req1_wrdata;
        req1_ready  = loc_ready;
        req1_rddata = loc_rddata;
      end
      default: ;
    endcase
  end

`ifdef UMI_LOC_ARB_STATS_EN
  always_ff @(posedge clk) begin
    if (!nreset) begin
      grant_count0 <= '0;
      grant_count1 <= '0;
    end else begin
      if (accept && (state == OWN0) && (grant_count0 != 32'hFFFF_FFFF))
        grant_count0 <= grant_count0 + 32'd1;
      if (accept && (state == OWN1) && (grant_count1 != 32'hFFFF_FFFF))
        grant_count1 <= grant_count1 + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_umi_loc_arbiter.sv
// Bench for umi_loc_arbiter: scenario table driven through a scoreboard, plus
// hand-written reset, stall and mid-transaction reset sequences.
module tb_umi_loc_arbiter;

  localparam int AW   = 16;
  localparam int DW   = 32;
  localparam int HOLD = 4;

  logic          clk = 1'b0;
  logic          nreset;
  logic [AW-1:0] req0_addr, req1_addr, loc_addr;
  logic          req0_write, req0_read, req1_write, req1_read, loc_write, loc_read;
  logic [7:0]    req0_opcode, req1_opcode, loc_opcode;
  logic [2:0]    req0_size, req1_size, loc_size;
  logic [7:0]    req0_len, req1_len, loc_len;
  logic [DW-1:0] req0_wrdata, req1_wrdata, loc_wrdata;
  logic          req0_ready, req1_ready, loc_ready;
  logic [DW-1:0] req0_rddata, req1_rddata, loc_rddata;
`ifdef UMI_LOC_ARB_STATS_EN
  logic [31:0]   grant_count0, grant_count1;
`endif

  always #5 clk = ~clk;

  umi_loc_arbiter #(.AW(AW), .DW(DW), .HOLD(HOLD)) dut (
    .clk(clk), .nreset(nreset),
    .req0_addr(req0_addr), .req0_write(req0_write), .req0_read(req0_read),
    .req0_opcode(req0_opcode), .req0_size(req0_size), .req0_len(req0_len),
    .req0_wrdata(req0_wrdata), .req0_ready(req0_ready), .req0_rddata(req0_rddata),
    .req1_addr(req1_addr), .req1_write(req1_write), .req1_read(req1_read),
    .req1_opcode(req1_opcode), .req1_size(req1_size), .req1_len(req1_len),
    .req1_wrdata(req1_wrdata), .req1_ready(req1_ready), .req1_rddata(req1_rddata),
    .loc_addr(loc_addr), .loc_write(loc_write), .loc_read(loc_read),
    .loc_opcode(loc_opcode), .loc_size(loc_size), .loc_len(loc_len),
    .loc_wrdata(loc_wrdata), .loc_ready(loc_ready), .loc_rddata(loc_rddata)
`ifdef UMI_LOC_ARB_STATS_EN
    , .grant_count0(grant_count0), .grant_count1(grant_count1)
`endif
  );

  // Small backing memory indexed by the low address bits.
  logic [DW-1:0] mem [16];
  always @(posedge clk) if (loc_write && loc_ready) mem[loc_addr[3:0]] <= loc_wrdata;
  assign loc_rddata = loc_read ? mem[loc_addr[3:0]] : '0;

  typedef struct {
    logic          who;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } exp_t;

  typedef struct {
    int          n0;
    int          n1;
    logic [15:0] pat;   // bit k = requester of the k-th accept
    int          a0;
    int          a1;
    int          first;
    int          last;
    int          gap;   // cycle where the port must be idle, -1 if none
  } vec_t;

  exp_t sb[$];
  bit   sb_en = 1'b0;
  int   checks = 0;
  int   errors = 0;
  int   acc0_total = 0;
  int   acc1_total = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Accept monitor: pops the scoreboard whenever a requester is accepted.
  always begin
    logic a0, a1;
    exp_t e;
    @(negedge clk);
    #2;
    if (nreset === 1'b1) begin
      a0 = req0_ready && (req0_write || req0_read);
      a1 = req1_ready && (req1_write || req1_read);
      if (a0) acc0_total++;
      if (a1) acc1_total++;
      if (sb_en && (a0 || a1)) begin
        if (sb.size() == 0) begin
          check("sb_unexpected", 64'd1, 64'd0);
        end else begin
          e = sb.pop_front();
          check("sb_accept", {a1, loc_addr, loc_wrdata}, {e.who, e.addr, e.data});
        end
      end
    end
  end

  task automatic drive0(input bit on, input int k, input int base);
    req0_write  = on;
    req0_read   = 1'b0;
    req0_addr   = on ? AW'(base + k) : '0;
    req0_wrdata = on ? DW'(32'hA0 + k) : '0;
    req0_opcode = on ? 8'h01 : 8'h00;
    req0_size   = on ? 3'd2 : 3'd0;
    req0_len    = 8'h00;
  endtask

  task automatic drive1(input bit on, input int k, input int base);
    req1_write  = on;
    req1_read   = 1'b0;
    req1_addr   = on ? AW'(base + k) : '0;
    req1_wrdata = on ? DW'(32'hB0 + k) : '0;
    req1_opcode = on ? 8'h02 : 8'h00;
    req1_size   = on ? 3'd2 : 3'd0;
    req1_len    = 8'h00;
  endtask

  task automatic do_reset();
    @(negedge clk);
    nreset    = 1'b0;
    loc_ready = 1'b1;
    drive0(1'b0, 0, 0);
    drive1(1'b0, 0, 0);
    @(negedge clk);
    nreset = 1'b1;
  endtask

  task automatic run_vec(input vec_t v);
    int   i0, i1, cyc, first, last, r1_hi, k0, k1;
    logic busy [64];
    exp_t e;
    do_reset();
    k0 = 0;
    k1 = 0;
    for (int k = 0; k < v.n0 + v.n1; k++) begin
      if (v.pat[k]) begin
        e.who = 1'b1; e.addr = AW'(v.a1 + k1); e.data = DW'(32'hB0 + k1); k1++;
      end else begin
        e.who = 1'b0; e.addr = AW'(v.a0 + k0); e.data = DW'(32'hA0 + k0); k0++;
      end
      sb.push_back(e);
    end
    sb_en = 1'b1;
    i0 = 0; i1 = 0; cyc = 0; first = -1; last = -1; r1_hi = 0;
    for (int k = 0; k < 64; k++) busy[k] = 1'b0;
    while ((i0 < v.n0 || i1 < v.n1) && cyc < 60) begin
      @(negedge clk);
      drive0(i0 < v.n0, i0, v.a0);
      drive1(i1 < v.n1, i1, v.a1);
      #1;
      busy[cyc] = loc_write | loc_read;
      if (req1_ready) r1_hi++;
      if ((req0_ready && req0_write) || (req1_ready && req1_write)) begin
        if (first < 0) first = cyc;
        last = cyc;
      end
      if (req0_ready && req0_write) i0++;
      if (req1_ready && req1_write) i1++;
      cyc++;
    end
    @(negedge clk);
    drive0(1'b0, 0, 0);
    drive1(1'b0, 0, 0);
    sb_en = 1'b0;
    check("vec_done", {32'(i0), 32'(i1)}, {32'(v.n0), 32'(v.n1)});
    check("vec_first", 64'(first), 64'(v.first));
    check("vec_last", 64'(last), 64'(v.last));
    check("sb_empty", 64'(sb.size()), 64'd0);
    if (v.gap >= 0) begin
      check("vec_gap_idle", 64'(busy[v.gap]), 64'd0);
      check("vec_gap_grant", 64'(busy[v.gap + 1]), 64'd1);
    end
    if (v.n1 == 0) check("vec_req1_quiet", 64'(r1_hi), 64'd0);
    for (int k = 0; k < v.n0; k++) check("mem0", mem[(v.a0 + k) % 16], 64'(32'hA0 + k));
    for (int k = 0; k < v.n1; k++) check("mem1", mem[(v.a1 + k) % 16], 64'(32'hB0 + k));
    sb.delete();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vecs[4];
    int   base0;
    vecs[0] = '{n0: 10, n1: 0, pat: 16'h0000, a0: 0, a1: 8, first: 1, last: 10, gap: -1};
    vecs[1] = '{n0: 8,  n1: 4, pat: 16'h00F0, a0: 0, a1: 8, first: 1, last: 12, gap: -1};
    vecs[2] = '{n0: 2,  n1: 2, pat: 16'h000C, a0: 0, a1: 8, first: 1, last: 5,  gap: 3};
    vecs[3] = '{n0: 3,  n1: 2, pat: 16'h0018, a0: 0, a1: 8, first: 1, last: 6,  gap: 4};

    // Reset held with both requesters pending.
    nreset    = 1'b0;
    loc_ready = 1'b1;
    drive0(1'b1, 1, 0);
    drive1(1'b1, 2, 0);
    req0_len = 8'h07;
    req1_len = 8'h03;
    @(posedge clk);
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      #1;
      check("rst_zero", 64'(|{loc_write, loc_read, loc_addr, loc_opcode, loc_size, loc_len,
                             loc_wrdata, req0_ready, req1_ready, req0_rddata, req1_rddata}), 64'd0);
    end
    @(negedge clk);
    nreset = 1'b1;
    #1;
    check("rst_release_idle", {req0_ready, req1_ready, loc_write}, 3'b000);
    @(negedge clk);
    #1;
    check("rst_first_grant", {req0_ready, req1_ready, loc_addr}, {1'b1, 1'b0, 16'd1});

    for (int i = 0; i < 4; i++) run_vec(vecs[i]);
`ifdef UMI_LOC_ARB_STATS_EN
    check("stat_cnt0", grant_count0, 64'd3);
    check("stat_cnt1", grant_count1, 64'd2);
`endif

    // Reset while req0 is stalled by the memory.
    do_reset();
    base0 = acc0_total;
    @(negedge clk);
    drive0(1'b1, 3, 0);
    loc_ready = 1'b0;
    @(negedge clk);
    #1;
    check("mid_owned", {req0_ready, loc_write, loc_addr}, {1'b0, 1'b1, 16'd3});
    @(negedge clk);
    nreset = 1'b0;
    @(negedge clk);
    nreset    = 1'b1;
    loc_ready = 1'b1;
    #1;
    check("mid_idle", {req0_ready, loc_write}, 2'b00);
    check("mid_noacc", 64'(acc0_total), 64'(base0));
`ifdef UMI_LOC_ARB_STATS_EN
    check("stat_rst", {grant_count0, grant_count1}, 64'd0);
`endif
    @(negedge clk);
    #1;
    check("mid_regrant", {req0_ready, loc_addr}, {1'b1, 16'd3});
    @(negedge clk);
    drive0(1'b0, 0, 0);
    check("mid_acc_once", 64'(acc0_total), 64'(base0 + 1));

    // Stall: req1 writes then reads address 5 with the memory busy for 3 cycles.
    do_reset();
    @(negedge clk);
    req1_write = 1'b1; req1_addr = 16'd5; req1_wrdata = 32'h55;
    #1;
    check("stall_idle", req1_ready, 64'd0);
    @(negedge clk);
    #1;
    check("stall_wr_acc", req1_ready, 64'd1);
    @(negedge clk);
    req1_write = 1'b0; req1_read = 1'b1; req1_wrdata = '0;
    drive0(1'b1, 7, 0);
    loc_ready = 1'b0;
    for (int s = 0; s < 3; s++) begin
      if (s > 0) @(negedge clk);
      #1;
      check("stall_hold", {req1_ready, req0_ready, loc_read, loc_addr}, {1'b0, 1'b0, 1'b1, 16'd5});
    end
    @(negedge clk);
    loc_ready = 1'b1;
    #1;
    check("stall_rd1", {req1_ready, req1_rddata}, {1'b1, 32'h55});
    check("stall_rd0", req0_rddata, 64'd0);
    @(negedge clk);
    #1;
    check("stall_acc3", req1_ready, 64'd1);
    @(negedge clk);
    #1;
    check("stall_acc4", req1_ready, 64'd1);
    @(negedge clk);
    #1;
    check("stall_handover", {req0_ready, req1_ready, loc_addr}, {1'b1, 1'b0, 16'd7});
    @(negedge clk);
    drive0(1'b0, 0, 0);
    drive1(1'b0, 0, 0);
    repeat (2) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
